// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Debounced capture of switch words into a FIFO, issued to the CPU
//            fetch stage over valid/ready in run (burst) or step mode.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int DEPTH           = 8,
    parameter int INSTR_W         = 18,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   btn_load,
    input  logic                   btn_run,
    input  logic                   btn_step,
    input  logic                   flush,
    input  logic [INSTR_W-1:0]     switches,
    output logic [INSTR_W-1:0]     instr_out,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int NBTN  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] press;

    assign btn_raw = {btn_step, btn_run, btn_load};

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            logic             sync1_q, sync1_d;
            logic             sync2_q, sync2_d;
            logic             deb_q, deb_d;
            logic             deb_prev_q, deb_prev_d;
            logic [DEB_W-1:0] cnt_q, cnt_d;

            // Counter runs only while the synchronized level disagrees with
            // the accepted level; any agreeing cycle restarts the count.
            always_comb begin
                sync1_d    = btn_raw[gi];
                sync2_d    = sync1_q;
                deb_prev_d = deb_q;
                deb_d      = deb_q;
                cnt_d      = '0;
                if (sync2_q != deb_q) begin
                    if (cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb_d = ~deb_q;
                    end else begin
                        cnt_d = cnt_q + DEB_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_q    <= 1'b0;
                    sync2_q    <= 1'b0;
                    deb_q      <= 1'b0;
                    deb_prev_q <= 1'b0;
                    cnt_q      <= '0;
                end else begin
                    sync1_q    <= sync1_d;
                    sync2_q    <= sync2_d;
                    deb_q      <= deb_d;
                    deb_prev_q <= deb_prev_d;
                    cnt_q      <= cnt_d;
                end
            end

            assign press[gi] = deb_q & ~deb_prev_q;
        end
    endgenerate

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    state_t             state_q, state_d;

    logic load_p, run_p, step_p;
    logic transfer, enq, deq;

    assign load_p   = press[0];
    assign run_p    = press[1];
    assign step_p   = press[2];
    assign transfer = instr_valid & instr_ready;
    assign deq      = transfer & ~flush;
    // A dequeue in the same cycle frees the head slot, so a full FIFO can
    // still accept the load.
    assign enq      = load_p & ~flush & (~full | transfer);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        state_d    = state_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            state_d    = ST_IDLE;
        end else begin
            if (enq) begin
                mem_d[wr_ptr_q] = switches;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
            if (load_p && !enq) begin
                overflow_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (run_p && !empty) begin
                        state_d = ST_RUN;
                    end else if (step_p && !empty) begin
                        state_d = ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (deq && (count_q == CNT_W'(1)) && !enq) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_STEP: begin
                    if (deq) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
        end
    end

    assign instr_out   = mem_q[rd_ptr_q];
    assign busy        = (state_q != ST_IDLE);
    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign instr_valid = busy & ~empty;
    assign fifo_count  = count_q;
    assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// Testbench for instr_sequencer: a queue-based FIFO model predicts issued
// words; a negedge monitor checks every transfer and the hold rule.
module tb_instr_sequencer;
    localparam int DEPTH   = 4;
    localparam int INSTR_W = 18;
    localparam int DEB     = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   btn_load = 1'b0;
    logic                   btn_run = 1'b0;
    logic                   btn_step = 1'b0;
    logic                   flush = 1'b0;
    logic [INSTR_W-1:0]     switches = '0;
    logic [INSTR_W-1:0]     instr_out;
    logic                   instr_valid;
    logic                   instr_ready = 1'b0;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   full;
    logic                   empty;
    logic                   overflow;

    instr_sequencer #(
        .DEPTH(DEPTH), .INSTR_W(INSTR_W), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset(reset), .btn_load(btn_load), .btn_run(btn_run),
        .btn_step(btn_step), .flush(flush), .switches(switches),
        .instr_out(instr_out), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .busy(busy), .fifo_count(fifo_count),
        .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int                 checks = 0;
    int                 failures = 0;
    int                 cyc = 0;
    logic [INSTR_W-1:0] exp_q[$];
    bit                 model_ovf = 1'b0;
    bit                 rand_ready = 1'b0;
    int                 xfer_cyc[$];
    bit                 hold_pend = 1'b0;
    logic [INSTR_W-1:0] held_word = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", 32'(instr_valid), 32'd1);
                chk("hold_word", 32'(instr_out), 32'(held_word));
            end
            if (instr_valid && instr_ready && !flush) begin
                xfer_cyc.push_back(cyc);
                chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("xfer_word", 32'(instr_out), 32'(exp_q.pop_front()));
            end
            hold_pend <= instr_valid && !instr_ready && !flush;
            held_word <= instr_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) instr_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic model_load(input logic [INSTR_W-1:0] w);
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else model_ovf = 1'b1;
    endtask

    // Press is accepted DEB+3 edges after the button rises; rdy pulses
    // instr_ready during exactly the press-pulse cycle.
    task automatic press_load(input logic [INSTR_W-1:0] w, input bit rdy);
        switches = w;
        btn_load = 1'b1;
        repeat (DEB + 2) tick();
        if (rdy) instr_ready = 1'b1;
        tick();
        if (rdy) instr_ready = 1'b0;
        model_load(w);
        btn_load = 1'b0;
        switches = INSTR_W'($urandom);
        repeat (DEB + 4) tick();
    endtask

    task automatic press_btn(input bit is_step);
        if (is_step) btn_step = 1'b1;
        else btn_run = 1'b1;
        repeat (DEB + 3) tick();
        btn_run  = 1'b0;
        btn_step = 1'b0;
        repeat (DEB + 4) tick();
    endtask

    task automatic status(input string tag);
        chk({tag, "_count"}, 32'(fifo_count), 32'(exp_q.size()));
        chk({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
        chk({tag, "_full"}, 32'(full), 32'(exp_q.size() == DEPTH));
        chk({tag, "_overflow"}, 32'(overflow), 32'(model_ovf));
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        model_ovf = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_within_budget", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) tick();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_instr_out", 32'(instr_out), 32'd0);
        reset = 1'b0;
        tick();

        // Run mode, ready held high
        press_load(18'h0A5A3, 1'b0);
        press_load(18'h12345, 1'b0);
        press_load(18'h3FFFF, 1'b0);
        status("run_pre");
        instr_ready = 1'b1;
        xfer_cyc.delete();
        press_btn(1'b0);
        chk("run_xfer_count", 32'(xfer_cyc.size()), 32'd3);
        if (xfer_cyc.size() == 3) begin
            chk("run_b2b_1", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd1);
            chk("run_b2b_2", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd1);
        end
        chk("run_done_busy", 32'(busy), 32'd0);
        status("run_post");

        // Step mode
        instr_ready = 1'b0;
        press_load(18'h0A5A3, 1'b0);
        press_load(18'h12345, 1'b0);
        press_load(18'h3FFFF, 1'b0);
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            press_btn(1'b1);
            chk("step_busy", 32'(busy), 32'd0);
            chk("step_valid_low", 32'(instr_valid), 32'd0);
            chk("step_count", 32'(fifo_count), 32'(2 - k));
            status("step");
        end

        // Backpressure in run mode
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) press_load(INSTR_W'($urandom), 1'b0);
        press_btn(1'b0);
        chk("bp_busy", 32'(busy), 32'd1);
        chk("bp_valid", 32'(instr_valid), 32'd1);
        repeat (5) tick();
        xfer_cyc.delete();
        for (int k = 0; k < 3; k++) begin
            instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
            tick();
            chk("bp_one_per_ready", 32'(xfer_cyc.size()), 32'(k + 1));
        end
        wait_idle(10);
        status("bp_post");

        // Overflow and load coinciding with a transfer while full
        for (int k = 0; k < 5; k++) begin
            press_load(INSTR_W'($urandom), 1'b0);
            if (k == 3) chk("full_after_4", 32'(full), 32'd1);
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(fifo_count), 32'd4);
        status("ovf");
        press_btn(1'b1);
        chk("step_hold_valid", 32'(instr_valid), 32'd1);
        press_load(INSTR_W'($urandom), 1'b1);
        chk("full_xfer_load_count", 32'(fifo_count), 32'd4);
        chk("full_xfer_idle", 32'(busy), 32'd0);
        status("full_xfer");

        // Flush mid-run
        press_btn(1'b0);
        chk("fl_busy_before", 32'(busy), 32'd1);
        do_flush();
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_valid", 32'(instr_valid), 32'd0);
        chk("fl_empty", 32'(empty), 32'd1);
        chk("fl_overflow", 32'(overflow), 32'd0);
        status("fl");

        // Glitch one cycle short of the debounce window, then a real press
        switches = INSTR_W'($urandom);
        btn_load = 1'b1;
        repeat (DEB - 1) tick();
        btn_load = 1'b0;
        repeat (DEB + 4) tick();
        chk("glitch_no_enq", 32'(fifo_count), 32'd0);
        press_load(INSTR_W'($urandom), 1'b0);
        chk("stable_one_enq", 32'(fifo_count), 32'd1);
        status("glitch");
        do_flush();

        // Randomized run sessions with random ready and refill while running
        rand_ready = 1'b1;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, DEPTH);
            for (int j = 0; j < n; j++) press_load(INSTR_W'($urandom), 1'b0);
            press_btn(1'b0);
            if ($urandom_range(0, 1) == 1) press_load(INSTR_W'($urandom), 1'b0);
            wait_idle(200);
            status("rand");
            do_flush();
        end
        rand_ready = 1'b0;
        instr_ready = 1'b0;

        // Asynchronous reset mid-run
        press_load(INSTR_W'($urandom), 1'b0);
        press_load(INSTR_W'($urandom), 1'b0);
        press_btn(1'b0);
        chk("ar_busy_before", 32'(busy), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", 32'(instr_valid), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_count", 32'(fifo_count), 32'd0);
        chk("ar_empty", 32'(empty), 32'd1);
        chk("ar_full", 32'(full), 32'd0);
        chk("ar_overflow", 32'(overflow), 32'd0);
        chk("ar_instr_out", 32'(instr_out), 32'd0);
        exp_q.delete();
        model_ovf = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        status("ar_post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
